// File: rtl/dff_pipe.sv
// Stallable, flushable register pipeline with per-stage valid bits and an occupancy count.
// DATA_RST selects whether the data stages are reset/flushed or are plain enable-only flops.
module dff_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      DEPTH    = 4,
  parameter bit               DATA_RST = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           d_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           q_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipe: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [OccW-1:0]  occ_q, occ_d;

  // Reset is applied in the flops; flush is folded into the next-state logic here.
  always_comb begin
    vld_d  = vld_q;
    occ_d  = occ_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = '0;
      occ_d = '0;
      if (DATA_RST) begin
        for (int k = 0; k < DEPTH; k++) begin
          data_d[k] = RST_VAL;
        end
      end
    end else if (en_i) begin
      vld_d[0]  = valid_i;
      data_d[0] = d_i;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
      occ_d = occ_q + OccW'(valid_i) - OccW'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  if (DATA_RST) begin : g_data_rst
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= RST_VAL;
        end
      end else begin
        data_q <= data_d;
      end
    end
  end else begin : g_data_nrst
    // No reset value: reset_n only acts as a hold enable so data stays unchanged.
    always_ff @(posedge clk) begin
      if (reset_n) begin
        data_q <= data_d;
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign q_o     = data_q[DEPTH-1];
  assign occ_o   = occ_q;

endmodule
